multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control unit for the multicycle variant of the processor: a Moore state machine that sequences one shared ALU, one unified instruction/data memory and the register file across 3–5 cycles per instruction. It also holds the N/Z/C/V condition flags and evaluates the ARM condition field. It sits beside the datapath, takes the instruction fields latched in the instruction register plus the live ALU flags, and drives every enable and mux select.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- Cond  in  4  instruction bits [31:28].
- Op  in  2  instruction bits [27:26].
- Funct  in  6  instruction bits [25:20].
- Rd  in  4  instruction bits [15:12].
- ALUFlags  in  4  live ALU flags {N,Z,C,V}.
- PCWrite  out  1  PC register enable.
- IRWrite  out  1  instruction register enable.
- RegWrite  out  1  register file write enable.
- MemWrite  out  1  memory write enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU direct.
- ALUSrcA  out  1  ALU A select: 0 = RD1, 1 = PC.
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ExtImm, 10 = constant 4.
- ImmSrc  out  2  immediate format; equals Op.
- RegSrc  out  2  [0] = Op==10 (read R15), [1] = Op==01 (read Rd as source).
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.

## Operation
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
- Transitions:
  - FETCH → DECODE.
  - DECODE: Op=00 → EXECUTEI if Funct[5], else EXECUTER; Op=01 → MEMADR; Op=10 → BRANCH; Op=11 → FETCH (undefined instruction is a NOP).
  - MEMADR: Funct[0]=1 → MEMRD, else MEMWR.
  - MEMRD → MEMWB.
  - EXECUTER and EXECUTEI → ALUWB.
  - MEMWB, MEMWR, ALUWB and BRANCH → FETCH.
  - Unused encodings 10–15 → FETCH.
- Per-state outputs (anything unlisted is 0):
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECUTER: ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - When ALUOp=0, ALUControl=00.
  - When ALUOp=1, Funct[4:1] maps 0100→00, 0010→01, 0000→10, 1100→11; any other value → 00.
  - FlagW[1] (N,Z) = ALUOp & Funct[0]; FlagW[0] (C,V) = ALUOp & Funct[0] & (ALUControl is ADD or SUB).
- Condition evaluation, from the stored flags:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL (1110) = 1; 1111 = 0.
- CondExD: a register that captures the condition result on the DECODE→next edge and holds it for the rest of the instruction. A flag update in EXECUTE therefore never changes the outcome of the same instruction's writeback.
- Flag registers:
  - NZ is loaded from ALUFlags[3:2] at the end of EXECUTER/EXECUTEI when FlagW[1] & CondExD.
  - CV is loaded from ALUFlags[1:0] under the same rule using FlagW[0].
- PCS = (Rd==1111 & RegW) | Branch.
- Write enables:
  - PCWrite = NextPC | (PCS & CondExD).
  - RegWrite = RegW & CondExD.
  - MemWrite = MemW & CondExD.
  - IRWrite is not gated by the condition.

## Timing
- Reset (asynchronous, active-low): state=FETCH, flags=0000, CondExD=0.
- While reset is low, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0; the mux selects show FETCH values.
- The first FETCH is the cycle after reset deasserts. Asserting reset mid-instruction aborts it with no further write.
- Cycles per instruction: data-processing (reg or imm) 4, LDR 5, STR 4, B 3, undefined 2.
- All outputs are Moore: they depend on state, latched fields and CondExD only, never combinationally on ALUFlags.
- A failed condition still consumes the full cycle count of its instruction class, with RegWrite, MemWrite and the PC-write term all 0.

## Test plan
- Reset held low for 3 cycles, then released → state=0, all write enables 0 during reset; FETCH cycle has IRWrite=1, PCWrite=1, ALUSrcB=10.
- ADDS R1,R2,R3 (Cond=1110, Op=00, Funct=001001) with ALUFlags=0100 → sequence FETCH, DECODE, EXECUTER (ALUControl=00), ALUWB (RegWrite=1); Z flag=1 afterwards.
- Following instruction ADDEQ R4,R4,#1 (Funct=101000) → EXECUTEI, RegWrite=1 in ALUWB. The same instruction with Cond=0001 (NE) → RegWrite=0, and it still takes 4 cycles.
- LDR (Op=01, Funct[0]=1) → FETCH, DECODE, MEMADR, MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegWrite=1): 5 cycles. STR (Funct[0]=0) → MEMWR with MemWrite=1: 4 cycles.
- B with Cond=1110 → BRANCH with PCWrite=1, 3 cycles. SUBS setting N≠V, then BLT → PCWrite=1; then BGE → PCWrite=0 in BRANCH.
- Op=11 → DECODE returns to FETCH with no write. Reset pulsed low during MEMRD → state=FETCH immediately, MEMWB never occurs.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Instruction-field / ALU-flag inputs and control outputs shared between
// the multicycle controller and its datapath.
interface multicycle_controller_if;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;

    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );

    modport master (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencer for the multicycle ARM-subset datapath, holding the NZCV
// flags and the per-instruction condition result.
module multicycle_controller (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       condex_q, condex_d;

    logic       irw, next_pc, regw, memw, branch, alu_op;
    logic       adr_src, src_a;
    logic [1:0] res_src, src_b;
    logic [1:0] alu_ctl, flag_w;
    logic       cond_ok, pcs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        irw     = 1'b0;
        next_pc = 1'b0;
        regw    = 1'b0;
        memw    = 1'b0;
        branch  = 1'b0;
        alu_op  = 1'b0;
        adr_src = 1'b0;
        src_a   = 1'b0;
        res_src = 2'b00;
        src_b   = 2'b00;
        case (state_q)
            FETCH: begin
                state_d = DECODE;
                irw     = 1'b1;
                next_pc = 1'b1;
                src_a   = 1'b1;
                src_b   = 2'b10;
                res_src = 2'b10;
            end
            DECODE: begin
                src_a   = 1'b1;
                src_b   = 2'b10;
                res_src = 2'b10;
                case (bus.Op)
                    2'b00:   state_d = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR: begin
                state_d = bus.Funct[0] ? MEMRD : MEMWR;
                src_b   = 2'b01;
            end
            MEMRD: begin
                state_d = MEMWB;
                adr_src = 1'b1;
            end
            MEMWB: begin
                res_src = 2'b01;
                regw    = 1'b1;
            end
            MEMWR: begin
                adr_src = 1'b1;
                memw    = 1'b1;
            end
            EXECUTER: begin
                state_d = ALUWB;
                alu_op  = 1'b1;
            end
            EXECUTEI: begin
                state_d = ALUWB;
                src_b   = 2'b01;
                alu_op  = 1'b1;
            end
            ALUWB: regw = 1'b1;
            BRANCH: begin
                src_b   = 2'b01;
                res_src = 2'b10;
                branch  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        alu_ctl = 2'b00;
        if (alu_op) begin
            case (bus.Funct[4:1])
                4'b0100: alu_ctl = 2'b00;
                4'b0010: alu_ctl = 2'b01;
                4'b0000: alu_ctl = 2'b10;
                4'b1100: alu_ctl = 2'b11;
                default: alu_ctl = 2'b00;
            endcase
        end
        flag_w[1] = alu_op & bus.Funct[0];
        flag_w[0] = alu_op & bus.Funct[0] & ~alu_ctl[1];
    end

    // Condition is judged against the stored flags, not the live ALU ones.
    always_comb begin
        case (bus.Cond)
            4'b0000: cond_ok = flags_q[2];
            4'b0001: cond_ok = ~flags_q[2];
            4'b0010: cond_ok = flags_q[1];
            4'b0011: cond_ok = ~flags_q[1];
            4'b0100: cond_ok = flags_q[3];
            4'b0101: cond_ok = ~flags_q[3];
            4'b0110: cond_ok = flags_q[0];
            4'b0111: cond_ok = ~flags_q[0];
            4'b1000: cond_ok = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ok = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ok = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ok = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ok = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ok = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        condex_d = (state_q == DECODE) ? cond_ok : condex_q;
        flags_d  = flags_q;
        if (flag_w[1] & condex_q) flags_d[3:2] = bus.ALUFlags[3:2];
        if (flag_w[0] & condex_q) flags_d[1:0] = bus.ALUFlags[1:0];
    end

    assign pcs = ((bus.Rd == 4'b1111) & regw) | branch;

    // Write enables are held off combinationally while reset is low.
    assign bus.PCWrite    = reset & (next_pc | (pcs & condex_q));
    assign bus.IRWrite    = reset & irw;
    assign bus.RegWrite   = reset & regw & condex_q;
    assign bus.MemWrite   = reset & memw & condex_q;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = res_src;
    assign bus.ALUSrcA    = src_a;
    assign bus.ALUSrcB    = src_b;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.ALUControl = alu_ctl;
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: each instruction pushes its expected per-cycle control
// vectors; a negedge monitor pops and compares them against the DUT.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if bus();
    multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [15:0] v;
        int          id;
        int          step;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] m_flags  = 4'b0000;
    int         instr_id = 0;

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // 0 ADD, 1 SUB, 2 AND, 3 ORR; unknown opcodes behave as ADD.
    function automatic logic [1:0] alu_of(input logic [5:0] fn);
        case (fn[4:1])
            4'b0010: return 2'd1;
            4'b0000: return 2'd2;
            4'b1100: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [15:0] vec(input logic [1:0] op, input bit pcw, input bit irw,
                                        input bit rw, input bit mw, input bit adr,
                                        input logic [1:0] res, input bit sa,
                                        input logic [1:0] sb, input logic [1:0] ac);
        logic [1:0] rs;
        rs = {op == 2'b01, op == 2'b10};
        return {pcw, irw, rw, mw, adr, res, sa, sb, op, rs, ac};
    endfunction

    function automatic logic [15:0] reset_vec(input logic [1:0] op);
        return vec(op, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00);
    endfunction

    always @(negedge clk) begin
        logic [15:0] got;
        exp_t        e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
                   bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc,
                   bus.ALUControl};
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL ctl instr=%0d step=%0d got=%b exp=%b", e.id, e.step, got, e.v);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v, input int step);
        exp_t e;
        e.v = v; e.id = instr_id; e.step = step;
        exp_q.push_back(e);
    endtask

    // Called at the start of the FETCH cycle; returns at the next FETCH.
    // abort_at >= 0 pulls reset low at the start of that cycle index.
    task automatic run_instr(input logic [3:0] cond, input logic [1:0] op,
                             input logic [5:0] fn, input logic [3:0] rd,
                             input logic [3:0] xflags, input int abort_at);
        logic [15:0] seq[5];
        logic [3:0]  fl[5];
        int          n;
        bit          ok;
        logic [1:0]  ac;
        bit          pc_rd;
        instr_id++;
        bus.Cond = cond; bus.Op = op; bus.Funct = fn; bus.Rd = rd;
        for (int k = 0; k < 5; k++) fl[k] = 4'($urandom);
        fl[2] = xflags;
        ok    = cond_ok(cond, m_flags);
        pc_rd = ok && (rd == 4'hF);
        seq[0] = vec(op, 1, 1, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00);
        seq[1] = vec(op, 0, 0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00);
        n = 2;
        case (op)
            2'b00: begin
                ac = alu_of(fn);
                seq[2] = vec(op, 0, 0, 0, 0, 0, 2'b00, 0, fn[5] ? 2'b01 : 2'b00, ac);
                seq[3] = vec(op, pc_rd, 0, ok, 0, 0, 2'b00, 0, 2'b00, 2'b00);
                n = 4;
                if (ok && fn[0]) begin
                    m_flags[3:2] = fl[2][3:2];
                    if (ac <= 2'd1) m_flags[1:0] = fl[2][1:0];
                end
            end
            2'b01: begin
                seq[2] = vec(op, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
                if (fn[0]) begin
                    seq[3] = vec(op, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00);
                    seq[4] = vec(op, pc_rd, 0, ok, 0, 0, 2'b01, 0, 2'b00, 2'b00);
                    n = 5;
                end else begin
                    seq[3] = vec(op, 0, 0, 0, ok, 1, 2'b00, 0, 2'b00, 2'b00);
                    n = 4;
                end
            end
            2'b10: begin
                seq[2] = vec(op, ok, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00);
                n = 3;
            end
            default: n = 2;
        endcase
        if (abort_at >= 0 && abort_at < n) n = abort_at;
        for (int k = 0; k < n; k++) push(seq[k], k);
        for (int k = 0; k < n; k++) begin
            bus.ALUFlags = fl[k];
            next_cycle();
        end
        if (abort_at >= 0) begin
            reset = 1'b0;
            m_flags = 4'b0000;
            push(reset_vec(op), 90);
            next_cycle();
            push(reset_vec(op), 91);
            next_cycle();
            reset = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b0;
        bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.ALUFlags = 4'd0;
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            push(reset_vec(2'b00), 80 + k);
            next_cycle();
        end
        reset = 1'b1;
        run_instr(4'hE, 2'b00, 6'b001001, 4'd1, 4'b0100, -1); // ADDS -> Z
        run_instr(4'h0, 2'b00, 6'b101000, 4'd4, 4'b1111, -1); // ADDEQ #1
        run_instr(4'h1, 2'b00, 6'b101000, 4'd4, 4'b0000, -1); // ADDNE #1
        run_instr(4'hE, 2'b01, 6'b011001, 4'd5, 4'b0000, -1); // LDR
        run_instr(4'hE, 2'b01, 6'b011000, 4'd5, 4'b0000, -1); // STR
        run_instr(4'hE, 2'b10, 6'b000000, 4'd0, 4'b0000, -1); // B
        run_instr(4'hE, 2'b00, 6'b000101, 4'd2, 4'b1000, -1); // SUBS N!=V
        run_instr(4'hB, 2'b10, 6'b000000, 4'd0, 4'b0000, -1); // BLT
        run_instr(4'hA, 2'b10, 6'b000000, 4'd0, 4'b0000, -1); // BGE
        run_instr(4'hE, 2'b11, 6'b111111, 4'd0, 4'b0000, -1); // undefined
        run_instr(4'hE, 2'b00, 6'b001000, 4'hF, 4'b0000, -1); // ADD PC,...
        run_instr(4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000, 3);  // LDR, reset in MEMRD
        run_instr(4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000, -1); // LDR after reset
        for (int i = 0; i < 400; i++) begin
            run_instr(4'($urandom), 2'($urandom), 6'($urandom), 4'($urandom),
                      4'($urandom), ($urandom_range(0, 39) == 0) ? int'($urandom_range(1, 4)) : -1);
        end
        for (int k = 0; k < 8 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
